// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle for rr_decode_arbiter.
// slave  = arbiter side: takes req/done, drives the grant outputs.
// master = requester side.
interface rr_decode_arbiter_if #(
  parameter int IDX_W = 2
);
  localparam int N = 1 << IDX_W;

  logic [N-1:0]     req;
  logic             done;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [N-1:0]     grant_oh;
  logic             timeout;

  modport slave (
    input  req, done,
    output grant_vld, grant_idx, grant_oh, timeout
  );

  modport master (
    output req, done,
    input  grant_vld, grant_idx, grant_oh, timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for N = 2**IDX_W requesters.
// The grant is held as a binary index and expanded to a one-hot select, one
// decode lane per requester (grant_oh[i] = grant_vld && grant_idx == i).
// Optional forced release after MAX_HOLD busy cycles: define RR_ARB_TIMEOUT_EN.
// Without it, timeout is tied 0 and a grant lasts until done or the req drop.

// One decode lane: the select line of requester LANE.
module rr_decode_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic             vld,
  input  logic [IDX_W-1:0] idx,
  output logic             sel
);
  assign sel = vld && (idx == IDX_W'(LANE));
endmodule

module rr_decode_arbiter #(
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_decode_arbiter_if.slave   bus
);
  localparam int N = 1 << IDX_W;

  // Refuse to elaborate outside the supported parameter range.
  if (IDX_W < 1 || IDX_W > 11 || MAX_HOLD < 2) begin : g_param_err
    $error("rr_decode_arbiter: IDX_W must be 1..11 and MAX_HOLD >= 2");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic             norm_rel;
  logic             to_rel;
  logic             rel;

  // Rotating priority scan: first requester at or after ptr, modulo N.
  // The index sum wraps naturally at IDX_W bits.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.req[ptr + IDX_W'(k)]) begin
        winner = ptr + IDX_W'(k);
        found  = 1'b1;
      end
    end
  end

  // Owner-driven release: explicit done, or the owner withdrew its request.
  assign norm_rel = bus.done || !bus.req[idx_q];

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  // Forced release only when the owner would otherwise keep the grant.
  assign to_rel = (hold_cnt == CNT_W'(MAX_HOLD - 1)) && !norm_rel;

  // Hold counter is zero on entry to BUSY and counts every BUSY cycle;
  // the timeout flag marks the edge that force-released the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_cnt  <= (state == BUSY) ? hold_cnt + CNT_W'(1) : '0;
      timeout_q <= (state == BUSY) && to_rel;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign to_rel      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign rel = norm_rel || to_rel;

  // Next-state: grant the scan winner from IDLE, release back to IDLE from BUSY.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx_q;
    case (state)
      IDLE: begin
        if (found) begin
          idx_nxt   = winner;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (rel) begin
          ptr_nxt   = idx_q + IDX_W'(1);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, rotation pointer and owner index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx_q <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      idx_q <= idx_nxt;
    end
  end

  assign bus.grant_vld = (state == BUSY);
  assign bus.grant_idx = idx_q;

  // Per-requester select lines from registered state only.
  for (genvar i = 0; i < N; i++) begin : g_lane
    rr_decode_lane #(.IDX_W(IDX_W), .LANE(i)) u_lane (
      .vld (bus.grant_vld),
      .idx (idx_q),
      .sel (bus.grant_oh[i])
    );
  end
endmodule
